tl_d_resp_sched: RTL and testbench

TileLink D-channel response scheduler for the single-slave memory endpoint. Pops completed-write and read requests from the request FIFO filled by the A-channel slave FSM, sequences beat-by-beat memory reads for Get requests, and drives AccessAck / AccessAckData responses to the master with a valid/ready handshake. One request is serviced at a time, in FIFO order.

---
 rtl/tl_d_resp_sched_if.sv | 27 ++
 rtl/tl_d_resp_sched.sv | 144 ++++++++++++++
 tb/tb_tl_d_resp_sched.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tl_d_resp_sched_if.sv
// Bundle of the request-FIFO, memory-read and TileLink D-channel signals
// seen by the response scheduler.
interface tl_d_resp_sched_if;
    logic [36:0] i_request;
    logic        i_empty_FIFO_request;
    logic        o_pop_request;
    logic        o_ren;
    logic [32:0] o_raddr;
    logic [63:0] i_rdata;
    logic        s_d_valid;
    logic        s_d_ready;
    logic [73:0] o_d_header;
    logic        o_err_drop;
    logic        o_busy;

    modport slave (
        input  i_request, i_empty_FIFO_request, i_rdata, s_d_ready,
        output o_pop_request, o_ren, o_raddr, s_d_valid, o_d_header,
        o_err_drop, o_busy
    );

    modport master (
        output i_request, i_empty_FIFO_request, i_rdata, s_d_ready,
        input  o_pop_request, o_ren, o_raddr, s_d_valid, o_d_header,
        o_err_drop, o_busy
    );
endinterface

// File: rtl/tl_d_resp_sched.sv
// TileLink D-channel response scheduler: pops one request at a time, reads Get
// data beat by beat and returns AccessAck / AccessAckData with valid/ready.
module tl_d_resp_sched #(
    parameter int band_width = 3,
    parameter int MAX_SIZE   = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    tl_d_resp_sched_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_ACK,
        S_RD,
        S_WAIT,
        S_DATA
    } state_t;

    localparam int BEAT_LOG = (MAX_SIZE > band_width) ? MAX_SIZE - band_width : 0;
    localparam int K_W      = (BEAT_LOG > 0) ? BEAT_LOG : 1;

    state_t         state_reg, state_next;
    logic [K_W-1:0] k_reg, k_next;
    logic [36:0]    req_reg, req_next;
    logic [63:0]    data_reg, data_next;
    logic           err_drop_reg, err_drop_next;

    logic [2:0]     req_op;
    logic [2:0]     req_size;
    logic [3:0]     req_mark;
    logic [26:0]    req_addr;
    logic [2:0]     head_op;
    logic [2:0]     sz;
    logic [3:0]     beat_log;
    logic [K_W-1:0] last_mask;
    logic           last_beat;
    logic [5:0]     offset;

    logic           pop_c;
    logic           ren_c;
    logic           valid_c;
    logic [73:0]    header_c;

    assign req_op   = req_reg[36:34];
    assign req_size = req_reg[33:31];
    assign req_mark = req_reg[30:27];
    assign req_addr = req_reg[26:0];
    assign head_op  = bus.i_request[36:34];

    assign sz       = (req_size > 3'(MAX_SIZE)) ? 3'(MAX_SIZE) : req_size;
    assign beat_log = ({1'b0, sz} > 4'(band_width)) ? ({1'b0, sz} - 4'(band_width)) : 4'd0;

    // Index of the final beat is a run of beat_log ones.
    generate
        for (genvar gi = 0; gi < K_W; gi++) begin : g_last_mask
            assign last_mask[gi] = (beat_log > 4'(gi));
        end
    endgenerate

    assign last_beat = (k_reg == last_mask);
    assign offset    = 6'(32'(k_reg) << band_width);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            k_reg        <= '0;
            req_reg      <= '0;
            data_reg     <= '0;
            err_drop_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            k_reg        <= k_next;
            req_reg      <= req_next;
            data_reg     <= data_next;
            err_drop_reg <= err_drop_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        k_next        = k_reg;
        req_next      = req_reg;
        data_next     = data_reg;
        err_drop_next = 1'b0;
        pop_c         = 1'b0;
        ren_c         = 1'b0;
        valid_c       = 1'b0;
        header_c      = '0;
        case (state_reg)
            S_IDLE: begin
                k_next = '0;
                if (!bus.i_empty_FIFO_request) begin
                    pop_c    = 1'b1;
                    req_next = bus.i_request;
                    case (head_op)
                        3'b000:  state_next = S_ACK;
                        3'b001:  state_next = S_RD;
                        default: err_drop_next = 1'b1;
                    endcase
                end
            end
            S_ACK: begin
                valid_c  = 1'b1;
                header_c = {3'd0, sz, req_mark, 64'd0};
                if (bus.s_d_ready) begin
                    state_next = S_IDLE;
                end
            end
            S_RD: begin
                ren_c      = 1'b1;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                data_next  = bus.i_rdata;
                state_next = S_DATA;
            end
            S_DATA: begin
                valid_c  = 1'b1;
                header_c = {3'd1, sz, req_mark, data_reg};
                if (bus.s_d_ready) begin
                    if (last_beat) begin
                        state_next = S_IDLE;
                    end else begin
                        k_next     = k_reg + K_W'(1);
                        state_next = S_RD;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Strobes are suppressed while reset is held, even before the first reset edge.
    assign bus.o_pop_request = pop_c & rst_n;
    assign bus.o_ren         = ren_c & rst_n;
    assign bus.s_d_valid     = valid_c & rst_n;
    assign bus.o_d_header    = rst_n ? header_c : 74'd0;
    assign bus.o_raddr       = {req_addr, offset};
    assign bus.o_err_drop    = err_drop_reg;
    assign bus.o_busy        = (state_reg != S_IDLE);

    logic unused_ok;
    assign unused_ok = ^req_op;
endmodule

// File: tb/tb_tl_d_resp_sched.sv
// Directed bench for tl_d_resp_sched: a FIFO and memory model feed the DUT,
// a scoreboard monitor checks every read address and D-channel response.
module tb_tl_d_resp_sched;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    tl_d_resp_sched_if bus();

    tl_d_resp_sched #(.band_width(3), .MAX_SIZE(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int pops_seen  = 0;
    int drops_seen = 0;

    logic [36:0] req_fifo[$];
    logic [73:0] exp_hdr_q[$];
    logic [32:0] exp_raddr_q[$];

    logic        pop_pend = 1'b0;
    logic        ren_pend = 1'b0;
    logic [32:0] ren_addr = '0;
    logic [63:0] mem_base = '0;
    logic        prev_stall = 1'b0;
    logic [73:0] prev_hdr = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [36:0] mk_req(input logic [2:0] op, input logic [2:0] size,
                                           input logic [3:0] mark, input logic [26:0] addr);
        return {op, size, mark, addr};
    endfunction

    function automatic logic [73:0] mk_hdr(input logic [2:0] op, input logic [2:0] size,
                                           input logic [3:0] mark, input logic [63:0] data);
        return {op, size, mark, data};
    endfunction

    function automatic logic [32:0] mk_raddr(input logic [26:0] addr, input int k);
        return {addr, 6'(k * 8)};
    endfunction

    task automatic refresh_fifo();
        bus.i_empty_FIFO_request = (req_fifo.size() == 0);
        bus.i_request = (req_fifo.size() == 0) ? 37'd0 : req_fifo[0];
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.s_d_valid) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 300; i++) begin
            if (req_fifo.size() == 0 && !bus.o_busy &&
                exp_hdr_q.size() == 0 && exp_raddr_q.size() == 0) break;
            tick(1);
        end
        check({name, "_busy"}, 128'(bus.o_busy), 128'd0);
        check({name, "_hdr_left"}, 128'(exp_hdr_q.size()), 128'd0);
        check({name, "_raddr_left"}, 128'(exp_raddr_q.size()), 128'd0);
    endtask

    // FIFO and memory models update just after the clock edge.
    always begin
        logic [36:0] dropped;
        @(posedge clk);
        #1;
        if (pop_pend && req_fifo.size() > 0) dropped = req_fifo.pop_front();
        refresh_fifo();
        if (ren_pend) bus.i_rdata = mem_base + 64'(ren_addr[5:3]);
    end

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        logic [73:0] eh;
        logic [32:0] ea;
        pop_pend <= rst_n && bus.o_pop_request;
        ren_pend <= rst_n && bus.o_ren;
        ren_addr <= bus.o_raddr;
        if (rst_n) begin
            if (bus.o_pop_request) begin
                pops_seen++;
                check("pop_when_empty", 128'(bus.i_empty_FIFO_request), 128'd0);
            end
            if (bus.o_err_drop) begin
                drops_seen++;
                $display("drop pulse at %0t", $time);
            end
            if (bus.o_ren) begin
                if (exp_raddr_q.size() == 0) begin
                    check("unexpected_ren", 128'(bus.o_ren), 128'd0);
                end else begin
                    ea = exp_raddr_q.pop_front();
                    $display("read raddr=%h", bus.o_raddr);
                    check("raddr", 128'(bus.o_raddr), 128'(ea));
                end
            end
            if (bus.s_d_valid && bus.s_d_ready) begin
                if (exp_hdr_q.size() == 0) begin
                    check("unexpected_resp", 128'(bus.s_d_valid), 128'd0);
                end else begin
                    eh = exp_hdr_q.pop_front();
                    $display("resp hdr=%h", bus.o_d_header);
                    check("d_header", 128'(bus.o_d_header), 128'(eh));
                end
            end
            if (prev_stall) begin
                check("stall_valid_hold", 128'(bus.s_d_valid), 128'd1);
                check("stall_hdr_hold", 128'(bus.o_d_header), 128'(prev_hdr));
            end
            prev_stall <= bus.s_d_valid && !bus.s_d_ready;
            prev_hdr   <= bus.o_d_header;
        end else begin
            prev_stall <= 1'b0;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int p0;
        int d0;

        rst_n         = 1'b0;
        bus.s_d_ready = 1'b0;
        bus.i_rdata   = '0;
        refresh_fifo();

        // Reset with a Put waiting, then back-pressured ack.
        req_fifo.push_back(mk_req(3'b000, 3'd3, 4'd5, 27'h10));
        exp_hdr_q.push_back(mk_hdr(3'd0, 3'd3, 4'd5, 64'd0));
        refresh_fifo();
        tick(1);
        for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            check("rst_pop", 128'(bus.o_pop_request), 128'd0);
            check("rst_ren", 128'(bus.o_ren), 128'd0);
            check("rst_valid", 128'(bus.s_d_valid), 128'd0);
            check("rst_raddr", 128'(bus.o_raddr), 128'd0);
            check("rst_hdr", 128'(bus.o_d_header), 128'd0);
            check("rst_drop", 128'(bus.o_err_drop), 128'd0);
            check("rst_busy", 128'(bus.o_busy), 128'd0);
            tick(1);
        end
        p0 = pops_seen;
        rst_n = 1'b1;
        @(negedge clk);
        check("first_pop", 128'(bus.o_pop_request), 128'd1);
        tick(1);
        wait_valid(ok);
        check("put_valid", 128'(ok), 128'd1);
        tick(3);
        bus.s_d_ready = 1'b1;
        tick(1);
        wait_idle("put");
        check("put_pops", 128'(pops_seen - p0), 128'd1);

        // Four-beat Get with ready held high.
        p0 = pops_seen;
        mem_base = 64'hA0;
        for (int k = 0; k < 4; k++) begin
            exp_raddr_q.push_back(mk_raddr(27'h40, k));
            exp_hdr_q.push_back(mk_hdr(3'd1, 3'd5, 4'd2, 64'hA0 + 64'(k)));
        end
        req_fifo.push_back(mk_req(3'b001, 3'd5, 4'd2, 27'h40));
        refresh_fifo();
        wait_idle("get4");
        check("get4_pops", 128'(pops_seen - p0), 128'd1);

        // Size 2 Get: single beat, latency pop -> ren -> wait -> valid.
        mem_base = 64'hB0;
        exp_raddr_q.push_back(mk_raddr(27'h80, 0));
        exp_hdr_q.push_back(mk_hdr(3'd1, 3'd2, 4'd1, 64'hB0));
        req_fifo.push_back(mk_req(3'b001, 3'd2, 4'd1, 27'h80));
        refresh_fifo();
        @(negedge clk);
        check("lat_pop", 128'(bus.o_pop_request), 128'd1);
        tick(1);
        @(negedge clk);
        check("lat_ren", 128'(bus.o_ren), 128'd1);
        check("lat_ren_novalid", 128'(bus.s_d_valid), 128'd0);
        tick(1);
        @(negedge clk);
        check("lat_wait_noren", 128'(bus.o_ren), 128'd0);
        check("lat_wait_novalid", 128'(bus.s_d_valid), 128'd0);
        tick(1);
        @(negedge clk);
        check("lat_valid", 128'(bus.s_d_valid), 128'd1);
        tick(1);
        wait_idle("get1");

        // Size 7 Get: clamped to size 6, eight beats.
        p0 = pops_seen;
        mem_base = 64'hC0;
        for (int k = 0; k < 8; k++) begin
            exp_raddr_q.push_back(mk_raddr(27'h100, k));
            exp_hdr_q.push_back(mk_hdr(3'd1, 3'd6, 4'd3, 64'hC0 + 64'(k)));
        end
        req_fifo.push_back(mk_req(3'b001, 3'd7, 4'd3, 27'h100));
        refresh_fifo();
        wait_idle("get8");
        check("get8_pops", 128'(pops_seen - p0), 128'd1);

        // Five-cycle stall on the second beat.
        bus.s_d_ready = 1'b0;
        mem_base = 64'hD0;
        for (int k = 0; k < 4; k++) begin
            exp_raddr_q.push_back(mk_raddr(27'h200, k));
            exp_hdr_q.push_back(mk_hdr(3'd1, 3'd5, 4'd7, 64'hD0 + 64'(k)));
        end
        req_fifo.push_back(mk_req(3'b001, 3'd5, 4'd7, 27'h200));
        refresh_fifo();
        for (int b = 0; b < 4; b++) begin
            wait_valid(ok);
            check("stall_beat_valid", 128'(ok), 128'd1);
            if (b == 1) begin
                repeat (5) begin
                    @(negedge clk);
                    check("stall_no_ren", 128'(bus.o_ren), 128'd0);
                    tick(1);
                end
            end
            bus.s_d_ready = 1'b1;
            tick(1);
            bus.s_d_ready = 1'b0;
        end
        wait_idle("stall");

        // Reset while the third beat is presented.
        p0 = pops_seen;
        mem_base = 64'hE0;
        for (int k = 0; k < 3; k++) exp_raddr_q.push_back(mk_raddr(27'h300, k));
        for (int k = 0; k < 2; k++) exp_hdr_q.push_back(mk_hdr(3'd1, 3'd5, 4'd4, 64'hE0 + 64'(k)));
        req_fifo.push_back(mk_req(3'b001, 3'd5, 4'd4, 27'h300));
        refresh_fifo();
        for (int b = 0; b < 3; b++) begin
            wait_valid(ok);
            check("rstmid_beat_valid", 128'(ok), 128'd1);
            if (b < 2) begin
                bus.s_d_ready = 1'b1;
                tick(1);
                bus.s_d_ready = 1'b0;
            end else begin
                rst_n = 1'b0;
                tick(1);
                rst_n = 1'b1;
            end
        end
        repeat (6) begin
            @(negedge clk);
            check("rstmid_no_valid", 128'(bus.s_d_valid), 128'd0);
            check("rstmid_no_pop", 128'(bus.o_pop_request), 128'd0);
            check("rstmid_busy", 128'(bus.o_busy), 128'd0);
            tick(1);
        end
        check("rstmid_pops", 128'(pops_seen - p0), 128'd1);
        bus.s_d_ready = 1'b1;
        exp_hdr_q.push_back(mk_hdr(3'd0, 3'd4, 4'hA, 64'd0));
        req_fifo.push_back(mk_req(3'b000, 3'd4, 4'hA, 27'h400));
        refresh_fifo();
        wait_idle("rstmid");

        // Illegal opcode followed by a Put.
        p0 = pops_seen;
        d0 = drops_seen;
        exp_hdr_q.push_back(mk_hdr(3'd0, 3'd0, 4'd6, 64'd0));
        req_fifo.push_back(mk_req(3'b100, 3'd3, 4'd9, 27'h20));
        req_fifo.push_back(mk_req(3'b000, 3'd0, 4'd6, 27'h30));
        refresh_fifo();
        @(negedge clk);
        check("ill_pop1", 128'(bus.o_pop_request), 128'd1);
        check("ill_drop_pre", 128'(bus.o_err_drop), 128'd0);
        tick(1);
        @(negedge clk);
        check("ill_pop2", 128'(bus.o_pop_request), 128'd1);
        check("ill_drop", 128'(bus.o_err_drop), 128'd1);
        check("ill_no_valid", 128'(bus.s_d_valid), 128'd0);
        tick(1);
        @(negedge clk);
        check("ill_put_valid", 128'(bus.s_d_valid), 128'd1);
        check("ill_drop_end", 128'(bus.o_err_drop), 128'd0);
        tick(1);
        wait_idle("illegal");
        check("ill_pops", 128'(pops_seen - p0), 128'd2);
        check("ill_drops", 128'(drops_seen - d0), 128'd1);

        bus.s_d_ready = 1'b0;
        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
